uart_tx_fifo: RTL and testbench
===============================

# uart_tx_fifo

Parametrised, buffered UART transmitter and the next generation of the SoC's single-byte transmitter. It accepts words over a valid/ready handshake into an internal FIFO and serialises them LSB-first. Data width, FIFO depth, stop-bit count and baud divisor are configurable, and optional parity can be compiled in. It sits between the bus-side UART register block and the `tx` pad.

## Interface
- DATA_BITS, 8: data bits per frame, 5..9
- FIFO_DEPTH, 4: buffer entries; power of two, ≥2
- DIV_WIDTH, 16: width of the divisor input
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- data_i  in  DATA_BITS  word to send
- valid_i  in  1  data_i valid
- ready_o  out  1  FIFO can accept a word (`!full`)
- div_i  in  DIV_WIDTH  bit period minus one, in clk cycles
- stop2_i  in  1  0 = one stop bit, 1 = two stop bits
- parity_mode_i  in  2  00 none, 01 even, 10 odd, 11 none; present only with the parity macro
- tx_o  out  1  serial line, idle high
- busy_o  out  1  frame in progress or FIFO non-empty
- level_o  out  $clog2(FIFO_DEPTH+1)  FIFO occupancy; excludes the word in the shifter

## Operation
- Push: a word is written when `valid_i && ready_o` at a clk edge. A push while full is impossible because `ready_o` is low; `valid_i` holds data until it is accepted.
- Push and pop may happen in the same cycle whenever the FIFO is not full. `level_o` is then unchanged.
- States are IDLE, START, DATA, PARITY and STOP.
  - IDLE, FIFO non-empty: pop, load the shifter, latch `div_i`/`stop2_i`/`parity_mode_i` for the whole frame, go to START.
  - START: `tx_o`=0 for one bit period.
  - DATA: DATA_BITS bits, LSB first, one bit period each.
  - PARITY (only if enabled and mode is 01/10): even = XOR of data bits; odd = its inverse.
  - STOP: `tx_o`=1 for 1 or 2 bit periods.
  - On the last STOP cycle: if the FIFO is non-empty, pop and go straight to START with no idle gap; otherwise go to IDLE.
- Bit counter: width $clog2(DATA_BITS). Period counter: DIV_WIDTH bits, loaded with the latched divisor and decremented to 0. `div_i`=0 gives one cycle per bit.
- Input changes during a frame affect only the next frame.
- Reset mid-frame: `tx_o`=1 immediately. The FIFO is emptied and the frame is lost.

## Timing
- Reset values: `tx_o`=1, `ready_o`=1, `busy_o`=0, `level_o`=0, state IDLE.
- `tx_o` is registered. A push at edge N into an empty, idle block drives `tx_o` low at edge N+1.
- Frame length is (1 + DATA_BITS + P + S)·(div+1) cycles, where P ∈ {0,1} and S ∈ {1,2}.
- `ready_o` and `level_o` update on the edge following the push/pop.
- `busy_o` falls on the edge at which STOP ends with the FIFO empty.

## Configuration
- Macro: UART_TX_FIFO_PARITY_EN.
- Defined: the `parity_mode_i` port and the PARITY state exist.
- Undefined: the port is absent, the PARITY state is not generated, and frames are always xN1/xN2.

## Structure
- Package `uart_pkg` holds:
  - `uart_tx_state_t` (IDLE, START, DATA, PARITY, STOP)
  - `uart_parity_t` (NONE, EVEN, ODD)
  - the localparam mapping of the 2-bit mode encoding
- Sub-module `uart_sync_fifo`, parametrised on width and depth: `push`/`pop`/`full`/`empty`/`count`. Its pointers carry an extra wrap bit so that full and empty are distinguishable.

## Test plan
- Reset → `tx_o`=1, `ready_o`=1, `busy_o`=0, `level_o`=0. Asserting `rst` mid-frame (data bit 3) gives `tx_o`=1 that same cycle and `level_o`=0. After release, the line stays idle.
- DATA_BITS=8, `div_i`=3, push 0xA5 → start low for 4 cycles, then bits 1,0,1,0,0,1,0,1 for 4 cycles each, then stop high for 4 cycles. The frame totals 40 cycles, and `busy_o` falls at the end of it.
- FIFO_DEPTH=4, `div_i`=9, `valid_i` held with 6 distinct words → words 0–4 are accepted (one goes into the shifter), `level_o` reaches 4 and `ready_o` goes low. Word 5 is accepted when frame 0 ends. The 6 frames are output back-to-back in order with no idle cycles.
- `stop2_i`=1, `div_i`=0, push 0xFF → 11-cycle frame: 1 low, 8 high, 2 high. The next frame's start bit follows immediately.
- UART_TX_FIFO_PARITY_EN, DATA_BITS=7, data 0x03: mode 10 gives parity bit 1; mode 01 gives 0; mode 00 gives no parity slot, for a frame of 9·(div+1) cycles.
- Change `div_i` from 3 to 1 mid-frame → the current frame keeps 4-cycle bits, and the next frame uses 2-cycle bits.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types for the buffered UART transmitter: FSM states, parity kinds
// and the 2-bit parity-mode encoding used on the register-block side.
package uart_pkg;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} uart_tx_state_t;
  typedef enum logic [1:0] {NONE, EVEN, ODD} uart_parity_t;

  localparam logic [1:0] MODE_NONE     = 2'b00;
  localparam logic [1:0] MODE_EVEN     = 2'b01;
  localparam logic [1:0] MODE_ODD      = 2'b10;
  localparam logic [1:0] MODE_NONE_ALT = 2'b11;

  function automatic uart_parity_t decode_parity(input logic [1:0] mode);
    case (mode)
      MODE_EVEN: return EVEN;
      MODE_ODD:  return ODD;
      default:   return NONE;
    endcase
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO; pointers carry one extra wrap bit so full and empty differ.
// DEPTH must be a power of two, at least 2.
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count   = wr_ptr - rd_ptr;
  assign dout    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: FIFO in front of an LSB-first serialiser.
// Optional parity slot is compiled in with UART_TX_FIFO_PARITY_EN.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int DIV_WIDTH  = 16
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [DATA_BITS-1:0]             data_i,
  input  logic                             valid_i,
  output logic                             ready_o,
  input  logic [DIV_WIDTH-1:0]             div_i,
  input  logic                             stop2_i,
`ifdef UART_TX_FIFO_PARITY_EN
  input  logic [1:0]                       parity_mode_i,
`endif
  output logic                             tx_o,
  output logic                             busy_o,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]  level_o,
  output uart_tx_state_t                   state_o
);

  localparam int BW = $clog2(DATA_BITS);
  localparam logic [BW-1:0]        LAST_BIT = BW'(DATA_BITS-1);
  localparam logic [BW-1:0]        BIT_ONE  = BW'(1);
  localparam logic [DIV_WIDTH-1:0] DIV_ONE  = DIV_WIDTH'(1);

  uart_tx_state_t             state_q, state_d;
  logic [DATA_BITS-1:0]       shift_q, shift_d;
  logic [BW-1:0]              bit_q, bit_d;
  logic [DIV_WIDTH-1:0]       period_q, period_d;
  logic [DIV_WIDTH-1:0]       div_q, div_d;
  logic                       stop2_q, stop2_d;
  logic                       stop_cnt_q, stop_cnt_d;
  logic                       tx_q, tx_d;
`ifdef UART_TX_FIFO_PARITY_EN
  logic                       par_en_q, par_en_d;
  logic                       par_bit_q, par_bit_d;
`endif

  logic [DATA_BITS-1:0]       fifo_dout;
  logic                       fifo_full;
  logic                       fifo_empty;
  logic                       fifo_pop;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;
  logic                       period_done;
  logic                       load;

  // Handshake: a word transfers on any clk edge where valid_i && ready_o;
  // the source holds data_i stable until that edge.
  uart_sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (valid_i),
    .pop   (fifo_pop),
    .din   (data_i),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign period_done = (period_q == '0);
  assign ready_o     = !fifo_full;
  assign level_o     = fifo_count;
  assign busy_o      = (state_q != IDLE) || !fifo_empty;
  assign tx_o        = tx_q;
  assign state_o     = state_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      bit_q      <= '0;
      period_q   <= '0;
      div_q      <= '0;
      stop2_q    <= 1'b0;
      stop_cnt_q <= 1'b0;
      tx_q       <= 1'b1;
`ifdef UART_TX_FIFO_PARITY_EN
      par_en_q   <= 1'b0;
      par_bit_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bit_q      <= bit_d;
      period_q   <= period_d;
      div_q      <= div_d;
      stop2_q    <= stop2_d;
      stop_cnt_q <= stop_cnt_d;
      tx_q       <= tx_d;
`ifdef UART_TX_FIFO_PARITY_EN
      par_en_q   <= par_en_d;
      par_bit_q  <= par_bit_d;
`endif
    end
  end

  // tx_d is the line level for the cycle after the edge, so tx_o is a pure flop.
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bit_d      = bit_q;
    period_d   = period_q;
    div_d      = div_q;
    stop2_d    = stop2_q;
    stop_cnt_d = stop_cnt_q;
    tx_d       = tx_q;
`ifdef UART_TX_FIFO_PARITY_EN
    par_en_d   = par_en_q;
    par_bit_d  = par_bit_q;
`endif
    fifo_pop   = 1'b0;
    load       = 1'b0;

    case (state_q)
      IDLE: begin
        if (!fifo_empty) load = 1'b1;
      end
      START: begin
        if (period_done) begin
          state_d  = DATA;
          period_d = div_q;
          bit_d    = '0;
          tx_d     = shift_q[0];
        end else begin
          period_d = period_q - DIV_ONE;
        end
      end
      DATA: begin
        if (period_done) begin
          period_d = div_q;
          if (bit_q == LAST_BIT) begin
`ifdef UART_TX_FIFO_PARITY_EN
            if (par_en_q) begin
              state_d = PARITY;
              tx_d    = par_bit_q;
            end else begin
              state_d    = STOP;
              tx_d       = 1'b1;
              stop_cnt_d = 1'b0;
            end
`else
            state_d    = STOP;
            tx_d       = 1'b1;
            stop_cnt_d = 1'b0;
`endif
          end else begin
            shift_d = shift_q >> 1;
            bit_d   = bit_q + BIT_ONE;
            tx_d    = shift_q[1];
          end
        end else begin
          period_d = period_q - DIV_ONE;
        end
      end
`ifdef UART_TX_FIFO_PARITY_EN
      PARITY: begin
        if (period_done) begin
          state_d    = STOP;
          period_d   = div_q;
          tx_d       = 1'b1;
          stop_cnt_d = 1'b0;
        end else begin
          period_d = period_q - DIV_ONE;
        end
      end
`endif
      STOP: begin
        if (period_done) begin
          if (stop2_q && !stop_cnt_q) begin
            stop_cnt_d = 1'b1;
            period_d   = div_q;
          end else if (!fifo_empty) begin
            load = 1'b1;
          end else begin
            state_d = IDLE;
            tx_d    = 1'b1;
          end
        end else begin
          period_d = period_q - DIV_ONE;
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
      end
    endcase

    // Frame settings are captured at pop so later input changes hit only the next frame.
    if (load) begin
      fifo_pop = 1'b1;
      state_d  = START;
      tx_d     = 1'b0;
      shift_d  = fifo_dout;
      period_d = div_i;
      div_d    = div_i;
      stop2_d  = stop2_i;
`ifdef UART_TX_FIFO_PARITY_EN
      par_en_d  = (decode_parity(parity_mode_i) != NONE);
      par_bit_d = (^fifo_dout) ^ (decode_parity(parity_mode_i) == ODD);
`endif
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: per-cycle comparison of the line,
// level, ready and busy against a frame-level reference model.
module tb_uart_tx_fifo;
  import uart_pkg::*;

  localparam int DATA_BITS  = 8;
  localparam int FIFO_DEPTH = 4;
  localparam int DIV_WIDTH  = 16;
  localparam int LW         = $clog2(FIFO_DEPTH+1);

  logic                 clk;
  logic                 rst;
  logic [DATA_BITS-1:0] data_i;
  logic                 valid_i;
  logic                 ready_o;
  logic [DIV_WIDTH-1:0] div_i;
  logic                 stop2_i;
`ifdef UART_TX_FIFO_PARITY_EN
  logic [1:0]           parity_mode_i;
`endif
  logic                 tx_o;
  logic                 busy_o;
  logic [LW-1:0]        level_o;
  uart_tx_state_t       state_o;

  uart_tx_fifo #(.DATA_BITS(DATA_BITS), .FIFO_DEPTH(FIFO_DEPTH), .DIV_WIDTH(DIV_WIDTH)) dut (
    .clk           (clk),
    .rst           (rst),
    .data_i        (data_i),
    .valid_i       (valid_i),
    .ready_o       (ready_o),
    .div_i         (div_i),
    .stop2_i       (stop2_i),
`ifdef UART_TX_FIFO_PARITY_EN
    .parity_mode_i (parity_mode_i),
`endif
    .tx_o          (tx_o),
    .busy_o        (busy_o),
    .level_o       (level_o),
    .state_o       (state_o)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- scoreboard / reference model ----------------
  int vectors    = 0;
  int miscompares = 0;
  bit chk_en     = 1'b0;
  int max_level  = 0;

  logic [DATA_BITS-1:0] exp_q[$];
  bit   act;
  int   t, d, nb;
  bit   fb [0:15];
  bit   do_push;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // A frame is a list of line levels, each held for d+1 cycles.
  function automatic void load_frame(input logic [DATA_BITS-1:0] w);
    d     = int'(div_i);
    fb[0] = 1'b0;
    for (int i = 0; i < DATA_BITS; i++) fb[1+i] = w[i];
    nb = 1 + DATA_BITS;
`ifdef UART_TX_FIFO_PARITY_EN
    if (parity_mode_i == 2'b01 || parity_mode_i == 2'b10) begin
      fb[nb] = (^w) ^ (parity_mode_i == 2'b10);
      nb++;
    end
`endif
    fb[nb] = 1'b1;
    nb++;
    if (stop2_i) begin
      fb[nb] = 1'b1;
      nb++;
    end
  endfunction

  initial begin
    act = 1'b0;
    t   = 0;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        exp_q.delete();
        act = 1'b0;
        t   = 0;
      end else begin
        do_push = valid_i && (exp_q.size() < FIFO_DEPTH);
        if (act && t == nb * (d + 1) - 1) act = 1'b0;
        else if (act) t++;
        if (!act && exp_q.size() > 0) begin
          load_frame(exp_q.pop_front());
          act = 1'b1;
          t   = 0;
        end
        if (do_push) exp_q.push_back(data_i);
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("tx",    tx_o,    act ? fb[t / (d + 1)] : 1'b1);
      check("level", level_o, exp_q.size());
      check("ready", ready_o, exp_q.size() < FIFO_DEPTH);
      check("busy",  busy_o,  act || exp_q.size() > 0);
      if (int'(level_o) > max_level) max_level = int'(level_o);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic [DATA_BITS-1:0] w);
    int n = 0;
    data_i  = w;
    valid_i = 1'b1;
    while (!ready_o && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("send_ready", ready_o, 1'b1);
    @(negedge clk);
    valid_i = 1'b0;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy_o && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check("idle_reached", busy_o, 1'b0);
  endtask

  // ---------------- stimulus ----------------
  int n;

  initial begin
    rst     = 1'b1;
    valid_i = 1'b0;
    data_i  = '0;
    div_i   = 16'd3;
    stop2_i = 1'b0;
`ifdef UART_TX_FIFO_PARITY_EN
    parity_mode_i = 2'b00;
`endif
    repeat (3) @(negedge clk);
    check("rst_tx",    tx_o,    1'b1);
    check("rst_ready", ready_o, 1'b1);
    check("rst_busy",  busy_o,  1'b0);
    check("rst_level", level_o, 0);
    check("rst_state", state_o, IDLE);
    rst    = 1'b0;
    chk_en = 1'b1;
    @(negedge clk);

    // Single 0xA5 frame, 4-cycle bits: 40-cycle frame plus the push cycle.
    div_i = 16'd3;
    send(8'hA5);
    wait_idle(n);
    check("a5_busy_cycles", n, 1 + (1 + 8 + 1) * 4);

    // Burst of 6 words held on valid with slow bits.
    div_i     = 16'd9;
    max_level = 0;
    for (int i = 0; i < 6; i++) send(DATA_BITS'(8'h10 + 8'(i * 17)));
    wait_idle(n);
    check("burst_max_level", max_level, FIFO_DEPTH);

    // Two stop bits, one cycle per bit, back-to-back.
    div_i   = 16'd0;
    stop2_i = 1'b1;
    send(8'hFF);
    send(8'h00);
    wait_idle(n);
    stop2_i = 1'b0;

    // Divisor change mid-frame affects only the following frame.
    div_i = 16'd3;
    send(8'h3C);
    send(8'hC3);
    repeat (10) @(negedge clk);
    div_i = 16'd1;
    wait_idle(n);

`ifdef UART_TX_FIFO_PARITY_EN
    div_i = 16'd1;
    for (int m = 0; m < 4; m++) begin
      parity_mode_i = 2'(m);
      send(8'h03);
      wait_idle(n);
      check("par_busy_cycles", n,
            1 + (1 + DATA_BITS + ((m == 1 || m == 2) ? 1 : 0) + 1) * 2);
    end
`endif

    // Randomised traffic with changing frame settings.
    for (int i = 0; i < 150; i++) begin
      div_i   = DIV_WIDTH'($urandom_range(0, 3));
      stop2_i = 1'($urandom_range(0, 1));
`ifdef UART_TX_FIFO_PARITY_EN
      parity_mode_i = 2'($urandom_range(0, 3));
`endif
      send(DATA_BITS'($urandom));
      if ($urandom_range(0, 9) == 0) repeat (60) @(negedge clk);
      else repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    wait_idle(n);

    // Reset during data bit 3 with a word still queued.
    div_i   = 16'd3;
    stop2_i = 1'b0;
    send(8'h5A);
    send(8'h96);
    repeat (16) @(negedge clk);
    check("pre_rst_level", level_o, 1);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_tx",    tx_o,    1'b1);
    check("mid_rst_level", level_o, 0);
    check("mid_rst_state", state_o, IDLE);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    check("post_rst_tx",   tx_o,   1'b1);
    check("post_rst_busy", busy_o, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #600000;
    miscompares++;
    $display("FAIL watchdog expired at %0t", $time);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
